microc_cu: RTL and testbench

Parametrised control unit for the microc single-cycle processor, replacing the testbench-driven control. It decodes the 6-bit opcode and the zero flag into datapath control (s_inc, s_inm, we3, wez, Op). It adds subroutine call/return through a hardware return-address stack (RAS), a HALT state, and sticky stack-error flags. It sits between the datapath's opcode/z outputs and its PC mux, register file and ALU.

---
 rtl/microc_pkg.sv | 29 ++
 rtl/microc_ras.sv | 79 +++++++
 rtl/microc_cu.sv | 146 ++++++++++++++
 tb/tb_microc_cu.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/microc_pkg.sv
// Shared definitions for the microc control unit: opcode encodings,
// ALU-prefix bit position, LI prefix helper and the control FSM states.
package microc_pkg;

  // Opcode bit that marks an ALU instruction (1xxxxx).
  localparam int OPC_ALU_BIT = 5;
  // LI is matched on opcode[5:2] only (0001xx).
  localparam int OPC_LI_LSB = 2;

  localparam logic [5:0] OPC_NOP  = 6'b000000;
  localparam logic [5:0] OPC_LI   = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b010000;
  localparam logic [5:0] OPC_JZ   = 6'b010001;
  localparam logic [5:0] OPC_JNZ  = 6'b010010;
  localparam logic [5:0] OPC_CALL = 6'b010011;
  localparam logic [5:0] OPC_RET  = 6'b010100;
  localparam logic [5:0] OPC_HLT  = 6'b011111;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // True for any opcode in the LI group (low two bits are don't-care).
  function automatic logic is_li(input logic [5:0] opc);
    return (opc[5:OPC_LI_LSB] == OPC_LI[5:OPC_LI_LSB]);
  endfunction

endpackage

// File: rtl/microc_ras.sv
// Hardware return-address stack for microc_cu.
// Build option MICROC_CU_TRAP_EN: when defined, an overflowing push is
// dropped and an underflowing pop leaves sp at 0 (the CU halts the core).
// When undefined, overflow drops the oldest entry to make room and
// underflow wraps sp to DEPTH-1, exposing stale contents.
module microc_ras #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] ret_addr,
  output logic            overflow,
  output logic            underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [PC_W-1:0] entry_r [DEPTH];
  logic [SP_W-1:0] sp_r;
  logic            full_s;
  logic            empty_s;
  logic [IDX_W-1:0] top_idx_s;
  logic [IDX_W-1:0] wr_idx_s;

  // Stack status, top-of-stack read and error pulses.
  always_comb begin
    full_s    = (sp_r == SP_W'(DEPTH));
    empty_s   = (sp_r == {SP_W{1'b0}});
    top_idx_s = IDX_W'(sp_r - {{(SP_W-1){1'b0}}, 1'b1});
    wr_idx_s  = IDX_W'(sp_r);
    overflow  = push & full_s;
    underflow = pop & empty_s;
    if (empty_s) begin
      ret_addr = {PC_W{1'b0}};
    end else begin
      ret_addr = entry_r[top_idx_s];
    end
  end

  // Storage and stack-pointer update on push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_r <= {SP_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= {PC_W{1'b0}};
      end
    end else if (push && !full_s) begin
      entry_r[wr_idx_s] <= push_data;
      sp_r <= sp_r + {{(SP_W-1){1'b0}}, 1'b1};
    end else if (push && full_s) begin
`ifdef MICROC_CU_TRAP_EN
      // Overflowing push is dropped; the CU traps into HALT.
      sp_r <= sp_r;
`else
      // Circular: shift out the oldest entry, new address becomes top.
      for (int i = 0; i < DEPTH-1; i++) begin
        entry_r[i] <= entry_r[i+1];
      end
      entry_r[DEPTH-1] <= push_data;
`endif
    end else if (pop && !empty_s) begin
      sp_r <= sp_r - {{(SP_W-1){1'b0}}, 1'b1};
    end else if (pop && empty_s) begin
`ifdef MICROC_CU_TRAP_EN
      sp_r <= {SP_W{1'b0}};
`else
      sp_r <= SP_W'(DEPTH-1);
`endif
    end else begin
      sp_r <= sp_r;
    end
  end

endmodule

// File: rtl/microc_cu.sv
// Control unit for the microc single-cycle processor: opcode/z decode,
// RUN/HALT FSM, subroutine call/return via microc_ras and sticky stack
// error flags. Build option MICROC_CU_TRAP_EN makes stack errors halt.
module microc_cu
  import microc_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      opcode,
  input  logic            z,
  input  logic [PC_W-1:0] pc_inc,
  output logic            s_inc,
  output logic            s_inm,
  output logic            we3,
  output logic            wez,
  output logic [2:0]      Op,
  output logic            s_ret,
  output logic [PC_W-1:0] ret_addr,
  output logic            pc_en,
  output logic            halted,
  output logic            ovf,
  output logic            unf
);

  state_t          state_r;
  logic            ovf_r;
  logic            unf_r;
  logic            dec_inc_s, dec_inm_s, dec_we3_s, dec_wez_s, dec_ret_s, dec_pcen_s;
  logic [2:0]      dec_op_s;
  logic            push_s, pop_s, hlt_s;
  logic [PC_W-1:0] ras_top_s;
  logic            ras_ovf_s, ras_unf_s;

  microc_ras #(.PC_W(PC_W), .DEPTH(DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_inc),
    .ret_addr  (ras_top_s),
    .overflow  (ras_ovf_s),
    .underflow (ras_unf_s)
  );

  // Instruction decode; HALT overrides everything with a frozen PC.
  always_comb begin
    dec_inc_s  = 1'b1;
    dec_inm_s  = 1'b0;
    dec_we3_s  = 1'b0;
    dec_wez_s  = 1'b0;
    dec_ret_s  = 1'b0;
    dec_pcen_s = 1'b1;
    dec_op_s   = 3'b000;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    hlt_s      = 1'b0;
    if (state_r == ST_RUN) begin
      if (opcode[OPC_ALU_BIT]) begin
        dec_we3_s = 1'b1;
        dec_wez_s = 1'b1;
        dec_op_s  = opcode[2:0];
      end else if (is_li(opcode)) begin
        dec_inm_s = 1'b1;
        dec_we3_s = 1'b1;
      end else begin
        case (opcode)
          OPC_J:    dec_inc_s = 1'b0;
          OPC_JZ:   dec_inc_s = ~z;
          OPC_JNZ:  dec_inc_s = z;
          OPC_CALL: begin
            dec_inc_s = 1'b0;
            push_s    = 1'b1;
          end
          OPC_RET:  begin
            dec_ret_s = 1'b1;
            pop_s     = 1'b1;
          end
          OPC_HLT:  hlt_s = 1'b1;
          default:  dec_inc_s = 1'b1;
        endcase
      end
    end else begin
      dec_pcen_s = 1'b0;
    end
  end

  // Output stage: reset forces every output to its idle value.
  always_comb begin
    if (!reset) begin
      s_inc    = 1'b1;
      s_inm    = 1'b0;
      we3      = 1'b0;
      wez      = 1'b0;
      Op       = 3'b000;
      s_ret    = 1'b0;
      ret_addr = {PC_W{1'b0}};
      pc_en    = 1'b0;
      halted   = 1'b0;
      ovf      = 1'b0;
      unf      = 1'b0;
    end else begin
      s_inc    = dec_inc_s;
      s_inm    = dec_inm_s;
      we3      = dec_we3_s;
      wez      = dec_wez_s;
      Op       = dec_op_s;
      s_ret    = dec_ret_s;
      ret_addr = ras_top_s;
      pc_en    = dec_pcen_s;
      halted   = (state_r == ST_HALT);
      ovf      = ovf_r;
      unf      = unf_r;
    end
  end

  // RUN/HALT state machine and sticky stack-error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      ovf_r <= ovf_r | ras_ovf_s;
      unf_r <= unf_r | ras_unf_s;
      case (state_r)
        ST_RUN: begin
`ifdef MICROC_CU_TRAP_EN
          if (hlt_s || ras_ovf_s || ras_unf_s) begin
`else
          if (hlt_s) begin
`endif
            state_r <= ST_HALT;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_microc_cu.sv
// Self-checking bench for microc_cu: directed scenarios followed by a
// random instruction stream, checked against a queue-based stack model.
module tb_microc_cu;

  localparam int PC_W  = 10;
  localparam int DEPTH = 4;

  localparam logic [5:0] NOP  = 6'b000000;
  localparam logic [5:0] J    = 6'b010000;
  localparam logic [5:0] JZ   = 6'b010001;
  localparam logic [5:0] JNZ  = 6'b010010;
  localparam logic [5:0] CALL = 6'b010011;
  localparam logic [5:0] RET  = 6'b010100;
  localparam logic [5:0] HLT  = 6'b011111;

  logic            clk;
  logic            reset;
  logic [5:0]      opcode;
  logic            z;
  logic [PC_W-1:0] pc_inc;
  logic            s_inc, s_inm, we3, wez, s_ret, pc_en, halted, ovf, unf;
  logic [2:0]      Op;
  logic [PC_W-1:0] ret_addr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PC_W-1:0] m_stack[$];
  bit              m_halted, m_ovf, m_unf, m_stale;

  microc_cu #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .pc_inc(pc_inc),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .s_ret(s_ret), .ret_addr(ret_addr), .pc_en(pc_en), .halted(halted),
    .ovf(ovf), .unf(unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one instruction, check all outputs mid-cycle, then advance the model.
  task automatic step(input logic [5:0] opc, input logic zv, input logic [PC_W-1:0] pci);
    logic e_inc, e_inm, e_we3, e_wez, e_ret, e_pcen;
    logic [2:0] e_op;
    logic [PC_W-1:0] e_top;
    opcode = opc; z = zv; pc_inc = pci;
    #3;
    e_inc = 1'b1; e_inm = 1'b0; e_we3 = 1'b0; e_wez = 1'b0;
    e_ret = 1'b0; e_pcen = 1'b1; e_op = 3'd0;
    e_top = (m_stack.size() > 0) ? m_stack[$] : {PC_W{1'b0}};
    if (m_halted) begin
      e_pcen = 1'b0;
    end else if (opc >= 6'd32) begin
      e_we3 = 1'b1; e_wez = 1'b1; e_op = 3'(opc % 8);
    end else if ((opc / 4) == 6'd1) begin
      e_inm = 1'b1; e_we3 = 1'b1;
    end else if (opc == J || opc == CALL) begin
      e_inc = 1'b0;
    end else if (opc == JZ) begin
      e_inc = (zv == 1'b0);
    end else if (opc == JNZ) begin
      e_inc = (zv == 1'b1);
    end else if (opc == RET) begin
      e_ret = 1'b1;
    end
    chk("s_inc", s_inc, e_inc);
    chk("s_inm", s_inm, e_inm);
    chk("we3", we3, e_we3);
    chk("wez", wez, e_wez);
    chk("Op", Op, e_op);
    chk("s_ret", s_ret, e_ret);
    chk("pc_en", pc_en, e_pcen);
    chk("halted", halted, m_halted);
    chk("ovf", ovf, m_ovf);
    chk("unf", unf, m_unf);
    if (!m_stale) chk("ret_addr", ret_addr, e_top);
    @(posedge clk);
    if (!m_halted) begin
      if (opc == CALL) begin
        if (m_stack.size() == DEPTH) begin
          m_ovf = 1'b1;
`ifdef MICROC_CU_TRAP_EN
          m_halted = 1'b1;
`else
          void'(m_stack.pop_front());
          m_stack.push_back(pci);
`endif
        end else begin
          m_stack.push_back(pci);
        end
      end else if (opc == RET) begin
        if (m_stack.size() == 0) begin
          m_unf = 1'b1;
`ifdef MICROC_CU_TRAP_EN
          m_halted = 1'b1;
`else
          m_stale = 1'b1;
          for (int i = 0; i < DEPTH-1; i++) m_stack.push_back({PC_W{1'b0}});
`endif
        end else begin
          void'(m_stack.pop_back());
        end
      end else if (opc == HLT) begin
        m_halted = 1'b1;
      end
    end
    #1;
  endtask

  // Hold reset for one cycle with the given opcode, checking forced outputs.
  task automatic do_reset(input logic [5:0] opc);
    reset = 1'b0; opcode = opc; z = 1'b1; pc_inc = 10'h3FF;
    #3;
    chk("rst_s_inc", s_inc, 1'b1);
    chk("rst_pc_en", pc_en, 1'b0);
    chk("rst_we3", we3, 1'b0);
    chk("rst_wez", wez, 1'b0);
    chk("rst_Op", Op, 3'd0);
    chk("rst_s_ret", s_ret, 1'b0);
    chk("rst_ret_addr", ret_addr, 10'd0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_unf", unf, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_stack.delete();
    m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_stale = 1'b0;
  endtask

  logic [5:0] odd_ops [12];

  initial begin
    reset = 1'b0; opcode = NOP; z = 1'b0; pc_inc = '0;
    odd_ops = '{6'b000001, 6'b000010, 6'b000011, 6'b001000, 6'b001101, 6'b001111,
                6'b010101, 6'b010110, 6'b011000, 6'b011010, 6'b011101, 6'b011110};
    @(posedge clk); #1;

    // Reset with ALU opcode, then the ALU opcode writes
    do_reset(6'b100010);
    step(6'b100010, 1'b0, 10'h001);
    chk("alu_we3_dir", we3, 1'b1);

    // Conditional jumps
    step(JZ, 1'b1, 10'h002);
    step(JZ, 1'b0, 10'h003);
    step(JNZ, 1'b1, 10'h004);
    step(JNZ, 1'b0, 10'h005);
    step(J, 1'b0, 10'h006);

    // Nested call/return
    step(CALL, 1'b0, 10'h005);
    step(CALL, 1'b0, 10'h0A0);
    step(RET, 1'b0, 10'h0A1);
    step(RET, 1'b0, 10'h006);
    step(NOP, 1'b0, 10'h006);
    chk("nested_empty", ret_addr, 10'h000);

    // Underflow
    step(RET, 1'b0, 10'h007);
    step(NOP, 1'b0, 10'h008);
    chk("unf_set", unf, 1'b1);
    do_reset(NOP);

    // Overflow with five calls
    for (int i = 1; i <= 5; i++) step(CALL, 1'b0, PC_W'(i * 16));
    step(NOP, 1'b0, 10'h100);
    chk("ovf_set", ovf, 1'b1);
`ifdef MICROC_CU_TRAP_EN
    chk("ovf_halt", halted, 1'b1);
`else
    chk("ovf_top", ret_addr, 10'h050);
`endif
    do_reset(NOP);

    // HLT blocks writes until reset
    step(HLT, 1'b0, 10'h001);
    step(6'b100111, 1'b0, 10'h002);
    step(6'b100111, 1'b0, 10'h002);
    do_reset(6'b100111);
    step(6'b100111, 1'b0, 10'h003);

    // Reset during CALL discards the push; then back-to-back CALL/RET
    step(CALL, 1'b0, 10'h111);
    do_reset(CALL);
    step(NOP, 1'b0, 10'h000);
    step(CALL, 1'b0, 10'h3AB);
    step(RET, 1'b0, 10'h000);
    step(NOP, 1'b0, 10'h000);

    // Random instruction stream
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [5:0] opc;
      r = $urandom_range(0, 15);
      case (r)
        0, 1, 2, 3: opc = 6'(6'd32 + 6'($urandom_range(0, 31)));
        4:          opc = NOP;
        5:          opc = 6'(6'd4 + 6'($urandom_range(0, 3)));
        6:          opc = J;
        7:          opc = JZ;
        8:          opc = JNZ;
        9, 10:      opc = CALL;
        11, 12:     opc = RET;
        13:         opc = odd_ops[$urandom_range(0, 11)];
        14:         opc = ($urandom_range(0, 3) == 0) ? HLT : NOP;
        default:    opc = NOP;
      endcase
      step(opc, 1'($urandom_range(0, 1)), PC_W'($urandom_range(0, 1023)));
      if ((m_halted || m_stale) && $urandom_range(0, 3) == 0) do_reset(opc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
